dice_reader: RTL and testbench

DICE_READER -- requirements
Module: dice_reader

---
 rtl/dice_pkg.sv | 28 ++
 rtl/dice_pip_decode.sv | 15 +
 rtl/dice_reader.sv | 152 +++++++++++++++
 tb/tb_dice_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice result reader.
// Holds the FSM state enum, face limits, score ceiling and pip table.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SETTLE
  } state_t;

  localparam logic [2:0] FACE_MIN  = 3'd1;
  localparam logic [2:0] FACE_MAX  = 3'd6;
  localparam logic [9:0] SCORE_MAX = 10'd1023;

  // bit 0 centre; 1/2 and 3/4 the diagonal corner pairs;
  // 5/6 the middle side pair; faces 0 and 7 light nothing
  localparam logic [7:0][6:0] PIP_TABLE = {
    7'b0000000,
    7'b1111110,
    7'b0011111,
    7'b0011110,
    7'b0000111,
    7'b0000110,
    7'b0000001,
    7'b0000000
  };

endpackage

// File: rtl/dice_pip_decode.sv
// Face value to die LED pattern lookup.
// Purely combinational; only instantiated with DICE_READER_PIP_EN.
module dice_pip_decode
  import dice_pkg::*;
(
  input  logic [2:0] face,
  output logic [6:0] pips
);

  // table lookup
  always_comb begin
    pips = PIP_TABLE[face];
  end

endmodule

// File: rtl/dice_reader.sv
// Captures a settled dice face after each button roll and keeps stats.
// Optional DICE_READER_PIP_EN adds a registered pips[6:0] LED output.
module dice_reader
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] throw,
  input  logic       clr,
  input  logic       res_ready,
  output logic       res_valid,
  output logic [2:0] res_value,
  output logic       res_double,
  output logic [7:0] roll_count,
  output logic [9:0] score_total,
  output logic       err,
`ifdef DICE_READER_PIP_EN
  output logic [6:0] pips,
`endif
  output logic       overrun
);

  state_t      state_q, state_d;
  logic        cap_vld_q, cap_vld_d;
  logic [2:0]  cap_face_q, cap_face_d;
  logic        res_valid_q, res_valid_d;
  logic [2:0]  res_value_q, res_value_d;
  logic        res_double_q, res_double_d;
  logic [7:0]  roll_count_q, roll_count_d;
  logic [9:0]  score_q, score_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;
  logic        prev_vld_q, prev_vld_d;
  logic [2:0]  prev_q, prev_d;
  logic        legal, commit, accept;
  logic [10:0] sum;

  // next-state: FSM, capture stage, result slot and statistics
  always_comb begin
    state_d      = state_q;
    cap_vld_d    = 1'b0;
    cap_face_d   = cap_face_q;
    res_valid_d  = res_valid_q;
    res_value_d  = res_value_q;
    res_double_d = res_double_q;
    roll_count_d = roll_count_q;
    score_d      = score_q;
    err_d        = err_q;
    overrun_d    = overrun_q;
    prev_vld_d   = prev_vld_q;
    prev_d       = prev_q;
    unique case (state_q)
      IDLE:    if (button) state_d = ROLLING;
      ROLLING: if (!button) state_d = SETTLE;
      SETTLE: begin
        state_d    = IDLE;
        cap_vld_d  = 1'b1;
        cap_face_d = throw;
      end
      default: state_d = IDLE;
    endcase
    legal  = (cap_face_q >= FACE_MIN) && (cap_face_q <= FACE_MAX);
    commit = cap_vld_q && legal;
    accept = res_valid_q && res_ready;
    sum    = {1'b0, score_q} + {8'd0, cap_face_q};
    if (commit) begin
      res_valid_d  = 1'b1;
      res_value_d  = cap_face_q;
      res_double_d = prev_vld_q && (prev_q == cap_face_q);
      roll_count_d = roll_count_q + 8'd1;
      score_d      = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
      prev_vld_d   = 1'b1;
      prev_d       = cap_face_q;
      if (res_valid_q && !res_ready) overrun_d = 1'b1;
    end else if (accept) begin
      res_valid_d = 1'b0;
    end
    if (cap_vld_q && !legal) err_d = 1'b1;
    if (clr) begin
      roll_count_d = 8'd0;
      score_d      = 10'd0;
      err_d        = 1'b0;
      overrun_d    = 1'b0;
      prev_vld_d   = 1'b0;
      prev_d       = 3'd0;
    end
  end

`ifdef DICE_READER_PIP_EN
  logic [6:0] pip_w;
  logic [6:0] pips_q, pips_d;

  dice_pip_decode u_pip (
    .face (res_value_d),
    .pips (pip_w)
  );

  // LED pattern follows the next result and blanks when nothing is valid
  always_comb begin
    pips_d = res_valid_d ? pip_w : 7'd0;
  end

  // pip register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pips_q <= 7'd0;
    else      pips_q <= pips_d;
  end

  assign pips = pips_q;
`endif

  // state and output registers; reset discards any roll and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cap_vld_q    <= 1'b0;
      cap_face_q   <= 3'd0;
      res_valid_q  <= 1'b0;
      res_value_q  <= 3'd0;
      res_double_q <= 1'b0;
      roll_count_q <= 8'd0;
      score_q      <= 10'd0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      prev_vld_q   <= 1'b0;
      prev_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      cap_vld_q    <= cap_vld_d;
      cap_face_q   <= cap_face_d;
      res_valid_q  <= res_valid_d;
      res_value_q  <= res_value_d;
      res_double_q <= res_double_d;
      roll_count_q <= roll_count_d;
      score_q      <= score_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
      prev_vld_q   <= prev_vld_d;
      prev_q       <= prev_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_value   = res_value_q;
  assign res_double  = res_double_q;
  assign roll_count  = roll_count_q;
  assign score_total = score_q;
  assign err         = err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dice_reader.sv
// Directed self-checking bench for dice_reader.
// Define DICE_READER_PIP_EN to also check the pips output.
module tb_dice_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw;
  logic       clr;
  logic       res_ready;
  logic       res_valid;
  logic [2:0] res_value;
  logic       res_double;
  logic [7:0] roll_count;
  logic [9:0] score_total;
  logic       err;
  logic       overrun;
`ifdef DICE_READER_PIP_EN
  logic [6:0] pips;
`endif

  int checks = 0;
  int errors = 0;

  dice_reader dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .throw       (throw),
    .clr         (clr),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .res_value   (res_value),
    .res_double  (res_double),
    .roll_count  (roll_count),
    .score_total (score_total),
    .err         (err),
`ifdef DICE_READER_PIP_EN
    .pips        (pips),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // press for hold cycles, release on face; rdy applied just before commit
  task automatic roll(input logic [2:0] face, input int hold,
                      input logic rdy);
    res_ready = 1'b0;
    button = 1'b1;
    cyc(hold);
    button = 1'b0;
    throw = face;
    cyc(2);
    res_ready = rdy;
    cyc(1);
  endtask

  initial begin
    rst = 1'b0; button = 1'b0; throw = 3'd0;
    clr = 1'b0; res_ready = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_value", 32'(res_value), 32'd0);
    chk("rst_count", 32'(roll_count), 32'd0);
    chk("rst_score", 32'(score_total), 32'd0);
    chk("rst_flags", 32'({err, overrun, res_double}), 32'd0);
`ifdef DICE_READER_PIP_EN
    chk("rst_pips", 32'(pips), 32'd0);
`endif
    rst = 1'b1;
    cyc(1);

    // basic roll: valid two cycles after first low sample
    button = 1'b1;
    cyc(10);
    button = 1'b0;
    throw = 3'd4;
    cyc(1);
    cyc(1);
    chk("basic_early", 32'(res_valid), 32'd0);
    cyc(1);
    chk("basic_valid", 32'(res_valid), 32'd1);
    chk("basic_value", 32'(res_value), 32'd4);
    chk("basic_count", 32'(roll_count), 32'd1);
    chk("basic_score", 32'(score_total), 32'd4);
    chk("basic_double", 32'(res_double), 32'd0);
`ifdef DICE_READER_PIP_EN
    chk("basic_pips", 32'(pips), 32'b0011110);
`endif
    cyc(3);
    chk("hold_value", 32'(res_value), 32'd4);
    chk("hold_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    cyc(1);
    chk("accept_drop", 32'(res_valid), 32'd0);
`ifdef DICE_READER_PIP_EN
    chk("accept_pips", 32'(pips), 32'd0);
`endif

    // double and acceptance
    roll(3'd3, 3, 1'b1);
    chk("dbl1_value", 32'(res_value), 32'd3);
    chk("dbl1_double", 32'(res_double), 32'd0);
    cyc(1);
    chk("dbl1_drop", 32'(res_valid), 32'd0);
    roll(3'd3, 3, 1'b1);
    chk("dbl2_valid", 32'(res_valid), 32'd1);
    chk("dbl2_double", 32'(res_double), 32'd1);
    chk("dbl2_score", 32'(score_total), 32'd10);
    cyc(1);
    chk("dbl2_drop", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // clear, then overrun
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_count", 32'(roll_count), 32'd0);
    chk("clr_score", 32'(score_total), 32'd0);
    roll(3'd2, 2, 1'b0);
    chk("ovr1_flag", 32'(overrun), 32'd0);
    chk("ovr1_double", 32'(res_double), 32'd0);
    roll(3'd5, 2, 1'b0);
    chk("ovr_value", 32'(res_value), 32'd5);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(roll_count), 32'd2);
    chk("ovr_score", 32'(score_total), 32'd7);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_keep_valid", 32'(res_valid), 32'd1);
    chk("clr_keep_value", 32'(res_value), 32'd5);
    chk("clr_overrun", 32'(overrun), 32'd0);
    res_ready = 1'b1;
    cyc(1);
    res_ready = 1'b0;
    chk("ovr_accept", 32'(res_valid), 32'd0);

    // illegal face
    roll(3'd7, 2, 1'b0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_valid", 32'(res_valid), 32'd0);
    chk("ill_count", 32'(roll_count), 32'd0);
    roll(3'd0, 2, 1'b0);
    chk("ill0_score", 32'(score_total), 32'd0);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("ill_clr_err", 32'(err), 32'd0);

    // saturation and wrap
    for (int i = 0; i < 256; i++) roll(3'd6, 1, 1'b1);
    chk("sat_score", 32'(score_total), 32'd1023);
    chk("wrap_count", 32'(roll_count), 32'd0);
    chk("sat_double", 32'(res_double), 32'd1);
    chk("sat_overrun", 32'(overrun), 32'd0);

    // new capture coinciding with acceptance
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    roll(3'd1, 2, 1'b0);
    roll(3'd2, 2, 1'b1);
    chk("coin_valid", 32'(res_valid), 32'd1);
    chk("coin_value", 32'(res_value), 32'd2);
    chk("coin_overrun", 32'(overrun), 32'd0);
    res_ready = 1'b0;

    // reset mid-roll with a pending result
    button = 1'b1;
    cyc(3);
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(res_valid), 32'd0);
    chk("mid_count", 32'(roll_count), 32'd0);
    chk("mid_score", 32'(score_total), 32'd0);
    chk("mid_value", 32'(res_value), 32'd0);
    button = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(5);
    chk("post_rst_valid", 32'(res_valid), 32'd0);

    // sub-cycle pulse between edges
    button = 1'b1;
    #2;
    button = 1'b0;
    cyc(5);
    chk("glitch_count", 32'(roll_count), 32'd0);

    // button back high during SETTLE
    button = 1'b1;
    cyc(3);
    button = 1'b0;
    throw = 3'd4;
    cyc(1);
    button = 1'b1;
    cyc(2);
    chk("resettle_value", 32'(res_value), 32'd4);
    chk("resettle_valid", 32'(res_valid), 32'd1);
    button = 1'b0;
    throw = 3'd6;
    cyc(3);
    chk("reroll_value", 32'(res_value), 32'd6);
    chk("reroll_count", 32'(roll_count), 32'd2);
    chk("reroll_overrun", 32'(overrun), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
